// File: rtl/adc_spi_responder.sv
// SPI mode-0 responder for the serial temperature ADC link.
// Oversamples CS_n/SCLK and shifts the held sample out MSB-first.
module adc_spi_responder #(
    parameter int DATA_W      = 8,
    parameter int LEAD_ZEROS  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              cs_n_in,
    input  logic              sclk_in,
    output logic              miso_out,
    output logic              miso_oe,
    output logic              busy,
    output logic              data_fresh,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              overrun
);

    localparam int SW = LEAD_ZEROS + DATA_W;
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] LAST_C = CW'(SW - 1);
    localparam logic [CW-1:0] PEN_C  = CW'(SW - 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL
    } state_t;

    state_t              state_q;
    logic [SW-1:0]       shift_q;
    logic [CW-1:0]       count_q;
    logic [DATA_W-1:0]   hold_q;
    logic                fresh_q;
    logic                miso_q;
    logic                oe_q;
    logic                busy_q;
    logic                done_q;
    logic                abort_q;
    logic                ovr_q;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;

    // Synchronizers track the pins even in reset, so no false edge follows reset.
    always_ff @(posedge clk) begin
        cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
        cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end

    logic cs_fall;
    logic cs_rise;
    logic sclk_fall;

    assign cs_fall   = cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
    assign cs_rise   = ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev_q & ~sclk_sync_q[SYNC_STAGES-1];

    logic [SW-1:0] load_d;
    logic [SW-1:0] shift_d;

    assign load_d  = SW'(hold_q);
    assign shift_d = {shift_q[SW-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            hold_q  <= '0;
            fresh_q <= 1'b0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            ovr_q   <= sample_valid & fresh_q;
            if (sample_valid) begin
                hold_q  <= sample_in;
                fresh_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= SHIFT;
                        shift_q <= load_d;
                        count_q <= '0;
                        oe_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        miso_q  <= load_d[SW-1];
                        if (!sample_valid) begin
                            fresh_q <= 1'b0;
                        end
                    end
                end
                SHIFT, TAIL: begin
                    // CS release outranks a coincident SCLK fall.
                    if (cs_rise) begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        miso_q  <= 1'b0;
                        if (count_q >= LAST_C) begin
                            done_q <= 1'b1;
                        end else begin
                            abort_q <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        shift_q <= shift_d;
                        miso_q  <= shift_d[SW-1];
                        if (state_q == SHIFT) begin
                            count_q <= count_q + 1'b1;
                            if (count_q == PEN_C) begin
                                state_q <= TAIL;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso_out    = miso_q;
    assign miso_oe     = oe_q;
    assign busy        = busy_q;
    assign data_fresh  = fresh_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: directed SPI frames against a
// sample/frame-level model of what the master must read.
module tb_adc_spi_responder;

    localparam int W  = 8;
    localparam int LZ = 1;
    localparam int SW = LZ + W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sample_in;
    logic         sample_valid;
    logic         cs_n;
    logic         sclk;
    logic         miso_out;
    logic         miso_oe;
    logic         busy;
    logic         data_fresh;
    logic         frame_done;
    logic         frame_abort;
    logic         overrun;

    adc_spi_responder #(
        .DATA_W(W),
        .LEAD_ZEROS(LZ),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .cs_n_in(cs_n),
        .sclk_in(sclk),
        .miso_out(miso_out),
        .miso_oe(miso_oe),
        .busy(busy),
        .data_fresh(data_fresh),
        .frame_done(frame_done),
        .frame_abort(frame_abort),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_abort = 0;
    int n_ovr = 0;
    bit started = 0;
    logic prev_done = 0;
    logic prev_abort = 0;

    // Model state: what the hold register, fresh flag and overrun tally must be.
    logic [W-1:0] m_hold;
    bit           m_fresh;
    int           m_ovr;
    int           last_word;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("miso_gated", int'(miso_out & ~miso_oe), 0);
            chk("busy_eq_oe", int'(busy), int'(miso_oe));
            chk("done_abort_excl", int'(frame_done & frame_abort), 0);
            chk("done_width", int'(frame_done & prev_done), 0);
            chk("abort_width", int'(frame_abort & prev_abort), 0);
            n_done  += int'(frame_done);
            n_abort += int'(frame_abort);
            n_ovr   += int'(overrun);
            prev_done  = frame_done;
            prev_abort = frame_abort;
        end
    end

    task automatic load(input logic [W-1:0] d);
        @(negedge clk);
        sample_in    = d;
        sample_valid = 1'b1;
        if (m_fresh) m_ovr++;
        m_fresh = 1;
        m_hold  = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic frame(input int n, input int sv_at,
                         input logic [W-1:0] sv_d, input int rst_at);
        int d0;
        int a0;
        int expb;
        bit reset_hit;
        logic [SW-1:0] img;
        img = SW'(m_hold);
        m_fresh = 0;
        d0 = n_done;
        a0 = n_abort;
        reset_hit = 0;
        last_word = 0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("oe_start", int'(miso_oe), 1);
        chk("busy_start", int'(busy), 1);
        chk("fresh_clr", int'(data_fresh), 0);
        for (int c = 1; c <= n; c++) begin
            if (c == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_outs", int'({miso_out, miso_oe, busy, data_fresh,
                    frame_done, frame_abort, overrun}), 0);
                rst = 1'b0;
                m_hold = '0;
                m_fresh = 0;
                reset_hit = 1;
                break;
            end
            if (c - 1 < LZ || c > SW) expb = 0;
            else expb = int'(img[SW-c]);
            chk("miso_bit", int'(miso_out), expb);
            last_word = (last_word << 1) | int'(miso_out);
            sclk = 1'b1;
            if (c == sv_at) begin
                load(sv_d);
                repeat (4) @(negedge clk);
            end else begin
                repeat (6) @(negedge clk);
            end
            sclk = 1'b0;
            repeat (6) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("oe_release", int'(miso_oe), 0);
        chk("busy_release", int'(busy), 0);
        chk("miso_release", int'(miso_out), 0);
        repeat (4) @(negedge clk);
        if (reset_hit) begin
            chk("rst_no_done", n_done - d0, 0);
            chk("rst_no_abort", n_abort - a0, 0);
        end else begin
            chk("done_cnt", n_done - d0, int'(n >= SW - 1));
            chk("abort_cnt", n_abort - a0, int'(n < SW - 1));
        end
        chk("ovr_total", n_ovr, m_ovr);
        chk("fresh_end", int'(data_fresh), int'(m_fresh));
    endtask

    initial begin
        int ov0;
        rst = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        sample_valid = 1'b0;
        sample_in = '0;
        m_hold = '0;
        m_fresh = 0;
        m_ovr = 0;
        repeat (4) @(negedge clk);
        chk("reset_outs", int'({miso_out, miso_oe, busy, data_fresh,
            frame_done, frame_abort, overrun}), 0);
        rst = 1'b0;
        started = 1;
        repeat (2) @(negedge clk);

        // Full frame of A5: master must see 0_1010_0101.
        load(8'hA5);
        repeat (2) @(negedge clk);
        chk("fresh_load", int'(data_fresh), 1);
        frame(9, 0, '0, 0);
        chk("word_A5", last_word, 'h0A5);

        // Short frame aborts.
        frame(4, 0, '0, 0);
        chk("word_abort", last_word, 'b0101);

        // Mid-frame load must not disturb the current frame.
        load(8'h5A);
        frame(9, 3, 8'h3C, 0);
        chk("word_5A", last_word, 'h05A);
        frame(9, 0, '0, 0);
        chk("word_3C", last_word, 'h03C);

        // Back-to-back loads: one overrun, newest value wins.
        ov0 = n_ovr;
        load(8'h11);
        load(8'h22);
        repeat (3) @(negedge clk);
        chk("ovr_once", n_ovr - ov0, 1);
        chk("fresh_two", int'(data_fresh), 1);
        frame(9, 0, '0, 0);
        chk("word_22", last_word, 'h022);

        // Over-long frame: trailing bits are zero.
        frame(12, 0, '0, 0);
        chk("word_long", last_word, 'h110);

        // Reset mid-frame, then the next frame carries the cleared hold.
        load(8'h77);
        frame(9, 5, '0, 5);
        frame(9, 0, '0, 0);
        chk("word_zero", last_word, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
